memory_core: RTL and testbench



---
 rtl/memory_core_pkg.sv | 50 +++++
 rtl/memory_core_sram_bank.sv | 24 ++
 rtl/memory_core.sv | 173 +++++++++++++++++
 tb/tb_memory_core.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_core_pkg.sv
// Shared widths, cfg register layout and helpers for the memory tile core.
// The optional SRAM readback path is selected by MEMORY_CORE_SRAM_READBACK_EN.
package memory_core_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BANK_WORDS  = 256;
  localparam int unsigned NUM_BANKS   = 4;
  localparam int unsigned MAX_DEPTH   = 1024;

  localparam int unsigned BANK_AW     = $clog2(BANK_WORDS);
  localparam int unsigned BANK_SEL_W  = $clog2(NUM_BANKS);
  localparam int unsigned LB_AW       = BANK_AW + BANK_SEL_W;
  localparam int unsigned DEPTH_W     = LB_AW + 1;

  localparam int unsigned CFG_W           = 16;
  localparam int unsigned CFG_MODE_LSB    = 0;
  localparam int unsigned CFG_MODE_W      = 2;
  localparam int unsigned CFG_TILE_EN_BIT = 2;
  localparam int unsigned CFG_DEPTH_LSB   = 3;
  localparam int unsigned CFG_DEPTH_W     = 13;
  localparam int unsigned CFG_ADDR_W      = 8;

  typedef enum logic [1:0] {
    MODE_LINEBUF = 2'd0,
    MODE_RSVD1   = 2'd1,
    MODE_RSVD2   = 2'd2,
    MODE_RSVD3   = 2'd3
  } mode_e;

  // The depth field is wider than the storage; anything above the bank capacity saturates.
  function automatic logic [DEPTH_W-1:0] clamp_depth(input logic [CFG_DEPTH_W-1:0] field);
    logic [DEPTH_W-1:0] res;
    if (field > CFG_DEPTH_W'(MAX_DEPTH)) begin
      res = DEPTH_W'(MAX_DEPTH);
    end else begin
      res = field[DEPTH_W-1:0];
    end
    return res;
  endfunction

  function automatic logic [BANK_SEL_W-1:0] lowest_bank(input logic [NUM_BANKS-1:0] sel);
    logic [BANK_SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (sel[i]) idx = BANK_SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/memory_core_sram_bank.sv
// Single-port synchronous RAM, read-before-write on a shared address, registered read data.
module sram_bank
  import memory_core_pkg::*;
(
  input  logic               clk_in,
  input  logic               we,
  input  logic               re,
  input  logic [BANK_AW-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem_q [BANK_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Read register only moves on a read, so it doubles as a hold register downstream.
  always_ff @(posedge clk_in) begin
    if (re) rdata_q <= mem_q[addr];
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_core.sv
// CGRA memory tile core: configurable-depth line buffer over four SRAM banks with config-bus access.
// Optional SRAM readback onto data_out is enabled by defining MEMORY_CORE_SRAM_READBACK_EN.
module memory_core
  import memory_core_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 config_en,
  input  logic [NUM_BANKS-1:0] config_en_sram,
  input  logic                 config_read,
  input  logic                 config_write,
  input  logic [31:0]          config_addr,
  input  logic [31:0]          config_data,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wen_in,
  input  logic                 ren_in,
  input  logic [DATA_W-1:0]    chain_in,
  input  logic                 flush,
  output logic [DATA_W-1:0]    data_out,
  output logic                 valid_out
);

  logic [CFG_W-1:0]      cfg_q, cfg_d;
  logic [LB_AW-1:0]      wptr_q, wptr_d;
  logic [DEPTH_W-1:0]    count_q, count_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic                  out_local_q, out_local_d;
  logic [BANK_SEL_W-1:0] out_bank_q, out_bank_d;

  logic [CFG_ADDR_W-1:0] cfg_word;
  logic                  cfg_reg_wr;
  logic [NUM_BANKS-1:0]  cfg_wr_sel;
  logic                  rb_req;
  logic [BANK_SEL_W-1:0] rb_bank;
  mode_e                 mode;
  logic                  tile_en;
  logic [DEPTH_W-1:0]    depth;
  logic                  lb_active;
  logic [BANK_SEL_W-1:0] lb_bank;
  logic                  lb_write;

  logic [NUM_BANKS-1:0]  bank_we;
  logic [NUM_BANKS-1:0]  bank_re;
  logic [BANK_AW-1:0]    bank_addr  [NUM_BANKS];
  logic [DATA_W-1:0]     bank_wdata [NUM_BANKS];
  logic [DATA_W-1:0]     bank_rdata [NUM_BANKS];

  assign cfg_word   = config_addr[31:24];
  assign cfg_reg_wr = config_en && (cfg_word == '0);
  assign cfg_wr_sel = config_write ? config_en_sram : '0;
  assign rb_bank    = lowest_bank(config_en_sram);

`ifdef MEMORY_CORE_SRAM_READBACK_EN
  assign rb_req = config_read && (|config_en_sram);
  logic unused_inputs;
  assign unused_inputs = ^{ren_in, chain_in, config_addr[23:0], config_data[31:16]};
`else
  assign rb_req = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{config_read, ren_in, chain_in, config_addr[23:0], config_data[31:16]};
`endif

  assign mode      = mode_e'(cfg_q[CFG_MODE_LSB +: CFG_MODE_W]);
  assign tile_en   = cfg_q[CFG_TILE_EN_BIT];
  assign depth     = clamp_depth(cfg_q[CFG_DEPTH_LSB +: CFG_DEPTH_W]);
  assign lb_active = tile_en && (mode == MODE_LINEBUF) && clk_en;
  assign lb_bank   = wptr_q[LB_AW-1 -: BANK_SEL_W];

  // A config write landing on the bank the stream targets wins the port; that sample is dropped.
  assign lb_write = lb_active && wen_in && !flush && (depth != '0) && !cfg_reg_wr
                    && !rb_req && !cfg_wr_sel[lb_bank];

  // Bank port steering: config accesses share one word address, the stream uses wptr.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b]    = cfg_wr_sel[b];
      bank_re[b]    = 1'b0;
      bank_addr[b]  = cfg_word;
      bank_wdata[b] = config_data[DATA_W-1:0];
    end
    if (rb_req) bank_re[rb_bank] = 1'b1;
    if (lb_write) begin
      bank_we[lb_bank]    = 1'b1;
      bank_re[lb_bank]    = 1'b1;
      bank_addr[lb_bank]  = wptr_q[BANK_AW-1:0];
      bank_wdata[lb_bank] = data_in;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    sram_bank u_bank (
      .clk_in (clk_in),
      .we     (bank_we[g]),
      .re     (bank_re[g]),
      .addr   (bank_addr[g]),
      .wdata  (bank_wdata[g]),
      .rdata  (bank_rdata[g])
    );
  end

  // Next-state for cfg, pointers and output source select.
  always_comb begin
    cfg_d       = cfg_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    valid_d     = valid_q;
    hold_d      = hold_q;
    out_local_d = out_local_q;
    out_bank_d  = out_bank_q;

    if (rb_req) begin
      out_local_d = 1'b0;
      out_bank_d  = rb_bank;
      valid_d     = 1'b0;
    end else if (clk_en && !cfg_reg_wr) begin
      if (flush) begin
        wptr_d      = '0;
        count_d     = '0;
        valid_d     = 1'b0;
        hold_d      = '0;
        out_local_d = 1'b1;
      end else if (!lb_active) begin
        valid_d = 1'b0;
      end else if (depth == '0) begin
        hold_d      = data_in;
        out_local_d = 1'b1;
        valid_d     = wen_in;
      end else if (lb_write) begin
        out_local_d = 1'b0;
        out_bank_d  = lb_bank;
        valid_d     = (count_q == depth);
        count_d     = (count_q == depth) ? count_q : count_q + DEPTH_W'(1);
        wptr_d      = (DEPTH_W'(wptr_q) == depth - DEPTH_W'(1)) ? '0 : wptr_q + LB_AW'(1);
      end else begin
        valid_d = 1'b0;
      end
    end

    if (cfg_reg_wr) begin
      cfg_d   = config_data[CFG_W-1:0];
      wptr_d  = '0;
      count_d = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cfg_q       <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      hold_q      <= '0;
      out_local_q <= 1'b1;
      out_bank_q  <= '0;
    end else begin
      cfg_q       <= cfg_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      hold_q      <= hold_d;
      out_local_q <= out_local_d;
      out_bank_q  <= out_bank_d;
    end
  end

  // Output is either the local hold register or a bank's read register.
  assign data_out  = out_local_q ? hold_q : bank_rdata[out_bank_q];
  assign valid_out = valid_q;

endmodule

// File: tb/tb_memory_core.sv
// Self-checking bench for memory_core: queue scoreboard over a behavioural line-buffer model,
// a vector table for pass-through mode, and hand sequences for config-port corners.
module tb_memory_core;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        config_en;
  logic [3:0]  config_en_sram;
  logic        config_read;
  logic        config_write;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic [15:0] data_in;
  logic        wen_in;
  logic        ren_in;
  logic [15:0] chain_in;
  logic        flush;
  logic [15:0] data_out;
  logic        valid_out;

  memory_core dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .clk_en         (clk_en),
    .config_en      (config_en),
    .config_en_sram (config_en_sram),
    .config_read    (config_read),
    .config_write   (config_write),
    .config_addr    (config_addr),
    .config_data    (config_data),
    .data_in        (data_in),
    .wen_in         (wen_in),
    .ren_in         (ren_in),
    .chain_in       (chain_in),
    .flush          (flush),
    .data_out       (data_out),
    .valid_out      (valid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    bit          known;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [15:0] din;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural reference: samples written since the last restart, oldest first.
  logic [15:0] hist[$];
  int          m_depth  = 0;
  bit          m_active = 1'b0;
  logic [15:0] m_data   = 16'h0;
  bit          m_known  = 1'b1;
  logic        m_valid  = 1'b0;

  function automatic void model_cfg(input logic [15:0] val);
    int f;
    f        = int'(val[15:3]);
    m_depth  = (f > 1024) ? 1024 : f;
    m_active = val[2] && (val[1:0] == 2'd0);
    hist.delete();
    m_valid  = 1'b0;
  endfunction

  function automatic void model_cycle(input bit ce, input bit fl, input bit we, input logic [15:0] d);
    if (!ce) return;
    if (fl) begin
      hist.delete();
      m_data = 16'h0; m_known = 1'b1; m_valid = 1'b0;
      return;
    end
    if (!m_active) begin
      m_valid = 1'b0;
      return;
    end
    if (m_depth == 0) begin
      m_data = d; m_known = 1'b1; m_valid = we;
      return;
    end
    if (!we) begin
      m_valid = 1'b0;
      return;
    end
    hist.push_back(d);
    if (hist.size() > m_depth) begin
      m_data = hist.pop_front(); m_known = 1'b1; m_valid = 1'b1;
    end else begin
      m_known = 1'b0; m_valid = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.valid = m_valid; e.data = m_data; e.known = m_known;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty, got valid=%b data=%h", name, valid_out, data_out);
      return;
    end
    e = exp_q.pop_front();
    chk({name, "_valid"}, 32'(valid_out), 32'(e.valid));
    if (e.known) chk({name, "_data"}, 32'(data_out), 32'(e.data));
  endtask

  task automatic cyc(input bit ce, input bit fl, input bit we, input logic [15:0] d, input string name);
    clk_en = ce; flush = fl; wen_in = we; data_in = d;
    model_cycle(ce, fl, we, d);
    push_exp();
    tick();
    sb_check(name);
  endtask

  task automatic cfg_write(input logic [15:0] val);
    config_en = 1'b1; config_addr = 32'h0; config_data = {16'h0, val};
    wen_in = 1'b0; flush = 1'b0;
    model_cfg(val);
    push_exp();
    tick();
    sb_check("cfg_wr");
    config_en = 1'b0;
  endtask

  // Config-port SRAM access with clk_en low; readback (if built) updates the expected output.
  task automatic sram_op(input logic [3:0] sel, input bit wr, input bit rd, input logic [7:0] word,
                         input logic [15:0] wdata, input logic [15:0] rb_exp, input string name);
    clk_en = 1'b0; wen_in = 1'b0; flush = 1'b0;
    config_en_sram = sel; config_write = wr; config_read = rd;
    config_addr = {word, 24'h0}; config_data = {16'h0, wdata};
`ifdef MEMORY_CORE_SRAM_READBACK_EN
    if (rd) begin
      m_data = rb_exp; m_known = 1'b1; m_valid = 1'b0;
    end
`endif
    push_exp();
    tick();
    sb_check(name);
    config_en_sram = 4'h0; config_write = 1'b0; config_read = 1'b0;
  endtask

  vec_t vt[6];
  int   idx;

  initial begin
    reset = 1'b1; clk_en = 1'b1; config_en = 1'b0; config_en_sram = 4'h0;
    config_read = 1'b0; config_write = 1'b0; config_addr = 32'h0; config_data = 32'h0;
    data_in = 16'h0; wen_in = 1'b0; ren_in = 1'b0; chain_in = 16'h0; flush = 1'b0;

    vt[0] = '{1'b1, 16'h0001, 1'b1, 16'h0001};
    vt[1] = '{1'b0, 16'h0002, 1'b0, 16'h0002};
    vt[2] = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF};
    vt[3] = '{1'b1, 16'h8000, 1'b1, 16'h8000};
    vt[4] = '{1'b0, 16'h1234, 1'b0, 16'h1234};
    vt[5] = '{1'b1, 16'h0000, 1'b1, 16'h0000};

    repeat (3) tick();
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_valid", 32'(valid_out), 32'h0);
    reset = 1'b0;

    cyc(1'b1, 1'b0, 1'b1, 16'h1111, "pre_cfg");

    // depth 10, tile enabled, line-buffer mode; gap in wen_in on cycles 15..20
    cfg_write(16'h0054);
    idx = 1;
    for (int c = 1; c <= 30; c++) begin
      if (c >= 15 && c <= 20) cyc(1'b1, 1'b0, 1'b0, 16'hDEAD, "gap");
      else begin
        cyc(1'b1, 1'b0, 1'b1, 16'(idx), "stream");
        idx++;
      end
    end

    repeat (3) cyc(1'b1, 1'b1, 1'b1, 16'hF00D, "flush");
    for (int c = 0; c < 12; c++) begin
      cyc(1'b1, 1'b0, 1'b1, 16'(idx), "post_flush");
      idx++;
    end

    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, c == 2, 1'($urandom_range(0, 1)), 16'($urandom), "clk_en_off");
    end
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, 1'b0, 1'b1, 16'(idx), "resume");
      idx++;
    end

    sram_op(4'b0001, 1'b1, 1'b0, 8'h07, 16'hBEEF, 16'h0000, "sram_wr");
    sram_op(4'b0001, 1'b0, 1'b1, 8'h07, 16'h0000, 16'hBEEF, "sram_rd");
    sram_op(4'b0001, 1'b1, 1'b1, 8'h07, 16'h1234, 16'hBEEF, "sram_rw_old");
    sram_op(4'b0001, 1'b0, 1'b1, 8'h07, 16'h0000, 16'h1234, "sram_rd_new");
    sram_op(4'b0010, 1'b1, 1'b0, 8'h03, 16'hA5A5, 16'h0000, "sram_wr_b1");
    sram_op(4'b0100, 1'b1, 1'b0, 8'h03, 16'h5A5A, 16'h0000, "sram_wr_b2");
    sram_op(4'b0110, 1'b0, 1'b1, 8'h03, 16'h0000, 16'hA5A5, "sram_rd_lowest");

    // depth 0: registered pass-through
    clk_en = 1'b1;
    cfg_write(16'h0004);
    for (int i = 0; i < 6; i++) begin
      clk_en = 1'b1; flush = 1'b0; wen_in = vt[i].wen; data_in = vt[i].din;
      model_cycle(1'b1, 1'b0, vt[i].wen, vt[i].din);
      tick();
      chk($sformatf("pass_valid[%0d]", i), 32'(valid_out), 32'(vt[i].exp_valid));
      chk($sformatf("pass_data[%0d]", i), 32'(data_out), 32'(vt[i].exp_data));
    end

    // depth field 2000 saturates to the 1024-word capacity
    cfg_write(16'h3E84);
    for (int i = 0; i < 1030; i++) cyc(1'b1, 1'b0, 1'b1, 16'(i + 'h100), "clamp");

    cfg_write(16'h0055);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 16'(i + 'h700), "mode_rsvd");

    cfg_write(16'h001C);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 16'(i + 'h900), "depth3");

    reset = 1'b1; flush = 1'b1; wen_in = 1'b1; data_in = 16'h4444;
    config_en = 1'b1; config_addr = 32'h0; config_data = 32'h54;
    tick();
    chk("midreset_data", 32'(data_out), 32'h0);
    chk("midreset_valid", 32'(valid_out), 32'h0);
    reset = 1'b0; config_en = 1'b0; flush = 1'b0;
    model_cfg(16'h0000);
    m_data = 16'h0; m_known = 1'b1;
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b1, 16'(i + 'hA00), "after_reset");

    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
